// File: rtl/count_up_down_mod.sv
// Up/down counter with configurable width, modulus, step and wrap/saturate mode.
// Registered count plus wrap pulse and sticky overflow/underflow flags.
module count_up_down_mod #(
   parameter int WIDTH    = 8,
   parameter int MODULO   = 256,
   parameter int STEP_W   = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              up_down,
   input  logic [STEP_W-1:0] step,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              clr_flags,
   output logic [WIDTH-1:0]  out,
   output logic              wrap_pulse,
   output logic              ovf_sticky,
   output logic              udf_sticky,
   output logic              at_max,
   output logic              at_min
);

   generate
      if (MODULO < (2 ** STEP_W) || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
         $error("count_up_down_mod: MODULO out of legal range");
      end
   endgenerate

   localparam int MAXV = MODULO - 1;
   localparam logic [WIDTH:0] MOD_W = MODULO[WIDTH:0];
   localparam logic [WIDTH:0] MAX_W = MAXV[WIDTH:0];

   logic [WIDTH-1:0] out_q, out_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;

   logic [WIDTH:0] out_x;
   logic [WIDTH:0] step_x;
   logic [WIDTH:0] sum;
   logic [WIDTH:0] nxt;
   logic           ovf_ev;
   logic           udf_ev;

   assign out_x  = {1'b0, out_q};
   assign step_x = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
   assign sum    = out_x + step_x;

   always_comb begin
      nxt    = out_x;
      ovf_ev = 1'b0;
      udf_ev = 1'b0;
      if (load) begin
         nxt = ({1'b0, load_val} < MOD_W) ? {1'b0, load_val} : MAX_W;
      end else if (en && step != '0) begin
         if (up_down) begin
            if (sum <= MAX_W) begin
               nxt = sum;
            end else begin
               ovf_ev = 1'b1;
               nxt    = SATURATE ? MAX_W : sum - MOD_W;
            end
         end else begin
            if (step_x <= out_x) begin
               nxt = out_x - step_x;
            end else begin
               udf_ev = 1'b1;
               nxt    = SATURATE ? '0 : out_x + MOD_W - step_x;
            end
         end
      end
   end

   // A boundary event in the same cycle as clr_flags keeps its flag set.
   always_comb begin
      out_d  = nxt[WIDTH-1:0];
      wrap_d = ovf_ev | udf_ev;
      ovf_d  = (ovf_q & ~clr_flags) | ovf_ev;
      udf_d  = (udf_q & ~clr_flags) | udf_ev;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q  <= '0;
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         out_q  <= out_d;
         wrap_q <= wrap_d;
         ovf_q  <= ovf_d;
         udf_q  <= udf_d;
      end
   end

   assign out        = out_q;
   assign wrap_pulse = wrap_q;
   assign ovf_sticky = ovf_q;
   assign udf_sticky = udf_q;
   assign at_max     = (out_x == MAX_W);
   assign at_min     = (out_q == '0);

endmodule

// File: tb/tb_count_up_down_mod.sv
// Bench: wrap and saturate instances (MODULO=200) share stimulus and are
// compared against an arithmetic reference model each cycle.
module tb_count_up_down_mod;

   localparam int W   = 8;
   localparam int SW  = 4;
   localparam int MOD = 200;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic          up_down;
   logic [SW-1:0] step;
   logic          load;
   logic [W-1:0]  load_val;
   logic          clr_flags;

   logic [W-1:0] out_w, out_s;
   logic         wp_w, wp_s, ovf_w, ovf_s, udf_w, udf_s;
   logic         amax_w, amax_s, amin_w, amin_s;

   int n_checks = 0;
   int n_errors = 0;

   int m_out [2];
   int m_wp  [2];
   int m_ovf [2];
   int m_udf [2];

   always #5 clk = ~clk;

   count_up_down_mod #(.WIDTH(W), .MODULO(MOD), .STEP_W(SW), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .reset(reset), .en(en), .up_down(up_down), .step(step),
      .load(load), .load_val(load_val), .clr_flags(clr_flags),
      .out(out_w), .wrap_pulse(wp_w), .ovf_sticky(ovf_w), .udf_sticky(udf_w),
      .at_max(amax_w), .at_min(amin_w)
   );

   count_up_down_mod #(.WIDTH(W), .MODULO(MOD), .STEP_W(SW), .SATURATE(1'b1)) u_sat (
      .clk(clk), .reset(reset), .en(en), .up_down(up_down), .step(step),
      .load(load), .load_val(load_val), .clr_flags(clr_flags),
      .out(out_s), .wrap_pulse(wp_s), .ovf_sticky(ovf_s), .udf_sticky(udf_s),
      .at_max(amax_s), .at_min(amin_s)
   );

   function automatic void model_step(int k, bit sat);
      int o, s;
      bit eo, eu;
      o  = m_out[k];
      s  = int'(step);
      eo = 0;
      eu = 0;
      if (reset) begin
         m_out[k] = 0; m_wp[k] = 0; m_ovf[k] = 0; m_udf[k] = 0;
         return;
      end
      if (load) begin
         o = (int'(load_val) < MOD) ? int'(load_val) : MOD - 1;
      end else if (en && s != 0) begin
         if (up_down) begin
            if (o + s <= MOD - 1) o = o + s;
            else begin eo = 1; o = sat ? MOD - 1 : o + s - MOD; end
         end else begin
            if (s <= o) o = o - s;
            else begin eu = 1; o = sat ? 0 : o + MOD - s; end
         end
      end
      m_out[k] = o;
      m_wp[k]  = (eo || eu) ? 1 : 0;
      m_ovf[k] = ((clr_flags ? 0 : m_ovf[k]) != 0 || eo) ? 1 : 0;
      m_udf[k] = ((clr_flags ? 0 : m_udf[k]) != 0 || eu) ? 1 : 0;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("w.out",  int'(out_w),  m_out[0]);
      chk("w.wrap", int'(wp_w),   m_wp[0]);
      chk("w.ovf",  int'(ovf_w),  m_ovf[0]);
      chk("w.udf",  int'(udf_w),  m_udf[0]);
      chk("w.max",  int'(amax_w), (m_out[0] == MOD - 1) ? 1 : 0);
      chk("w.min",  int'(amin_w), (m_out[0] == 0) ? 1 : 0);
      chk("s.out",  int'(out_s),  m_out[1]);
      chk("s.wrap", int'(wp_s),   m_wp[1]);
      chk("s.ovf",  int'(ovf_s),  m_ovf[1]);
      chk("s.udf",  int'(udf_s),  m_udf[1]);
      chk("s.max",  int'(amax_s), (m_out[1] == MOD - 1) ? 1 : 0);
      chk("s.min",  int'(amin_s), (m_out[1] == 0) ? 1 : 0);
   endtask

   task automatic cyc(input bit r, input bit l, input int lv, input bit e,
                      input bit ud, input int st, input bit cf);
      reset     = r;
      load      = l;
      load_val  = lv[W-1:0];
      en        = e;
      up_down   = ud;
      step      = st[SW-1:0];
      clr_flags = cf;
      @(posedge clk);
      model_step(0, 1'b0);
      model_step(1, 1'b1);
      #1;
      check_all();
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_out[k] = 0; m_wp[k] = 0; m_ovf[k] = 0; m_udf[k] = 0;
      end
      reset = 1; load = 1; load_val = 8'd5; en = 1;
      up_down = 1; step = 4'd1; clr_flags = 0;
      #1;

      // reset overrides load and enable
      cyc(1, 1, 5, 1, 1, 1, 0);
      cyc(1, 1, 5, 1, 1, 1, 0);
      chk("rst.out", int'(out_w), 0);
      cyc(0, 0, 0, 1, 1, 1, 0);
      cyc(0, 0, 0, 1, 1, 1, 0);
      cyc(0, 0, 0, 1, 1, 1, 0);
      chk("cnt3", int'(out_w), 3);

      // overflow: wrap gives 1, saturate clamps at 199
      cyc(0, 1, 198, 0, 1, 3, 0);
      cyc(0, 0, 0, 1, 1, 3, 0);
      chk("ovf.wrap.out", int'(out_w), 1);
      chk("ovf.sat.out", int'(out_s), 199);
      cyc(0, 0, 0, 1, 1, 3, 0);
      chk("ovf.wrap.pulse1", int'(wp_w), 0);
      chk("ovf.sat.pulse2", int'(wp_s), 1);

      // underflow
      cyc(0, 1, 2, 0, 0, 5, 1);
      cyc(0, 0, 0, 1, 0, 5, 0);
      chk("udf.wrap.out", int'(out_w), 197);
      cyc(0, 1, 1, 0, 0, 4, 0);
      cyc(0, 0, 0, 1, 0, 4, 0);
      chk("udf.sat.out", int'(out_s), 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 7, 0);

      // load beats enable; out-of-range load clamps
      cyc(0, 1, 250, 1, 1, 5, 0);
      chk("load.clamp", int'(out_w), 199);
      chk("load.atmax", int'(amax_w), 1);

      // clr with concurrent overflow, then clr alone
      cyc(0, 0, 0, 1, 1, 2, 1);
      chk("clr.ovf.keep", int'(ovf_w), 1);
      cyc(0, 0, 0, 0, 1, 2, 1);
      chk("clr.ovf.gone", int'(ovf_w), 0);
      cyc(0, 0, 0, 1, 1, 9, 0);
      cyc(1, 0, 0, 1, 1, 9, 0);
      chk("rst.mid", int'(out_s), 0);

      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 49) == 0),
             ($urandom_range(0, 11) == 0),
             int'($urandom_range(0, 255)),
             ($urandom_range(0, 4) != 0),
             $urandom_range(0, 1),
             int'($urandom_range(0, 15)),
             ($urandom_range(0, 9) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
